// File: rtl/matrix_pkg.sv
// Shared definitions for the Kronecker product stream engine.
//   - kron_state_t : engine FSM state (IDLE waits for operands, RUN streams results)
//   - DEF_*        : default operand geometry and element width
//   - clog2        : ceiling log2 for elaboration-time width calculations
//   - res_rows / res_cols / elem_count : result geometry derived from the operand shapes
//   - idx_width    : width of an index/counter that must hold 0..n-1 (at least 1 bit)
package matrix_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } kron_state_t;

    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_M         = 2;
    localparam int DEF_N         = 2;
    localparam int DEF_P         = 2;
    localparam int DEF_Q         = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Result geometry is a function of each instance's parameters, so it is
    // provided as constant functions usable in parameter/port declarations.
    function automatic int res_rows(input int m, input int p);
        return m * p;
    endfunction

    function automatic int res_cols(input int n, input int q);
        return n * q;
    endfunction

    function automatic int elem_count(input int m, input int n, input int p, input int q);
        return m * n * p * q;
    endfunction

    function automatic int idx_width(input int n);
        return clog2((n < 2) ? 2 : n);
    endfunction

endpackage

// File: rtl/matrix_kronecker_stream_index_counter.sv
// kron_index_counter: four-level nested wrap counter walking the Kronecker
// result in row-major order (l fastest, then j, then k, then i).
// The i/j/k/l, row/col and last outputs describe the element selected for the
// current cycle: the stored position, or position 0 when clear_i is high.
// advance_i steps the stored position one element beyond the selected one.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear_i           restart from element 0 this cycle
//   advance_i         step past the selected element at the next edge
//   i_o, j_o, k_o, l_o  selected A row/col and B row/col
//   row_o, col_o      selected result row (i*p+k) and column (j*q+l)
//   last_o            selected element is the final one of the result
module kron_index_counter
    import matrix_pkg::*;
#(
    parameter int M  = DEF_M,
    parameter int N  = DEF_N,
    parameter int P  = DEF_P,
    parameter int Q  = DEF_Q,
    parameter int IW = idx_width(M),
    parameter int JW = idx_width(N),
    parameter int KW = idx_width(P),
    parameter int LW = idx_width(Q),
    parameter int RW = idx_width(res_rows(M, P)),
    parameter int CW = idx_width(res_cols(N, Q))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [IW-1:0] i_o,
    output logic [JW-1:0] j_o,
    output logic [KW-1:0] k_o,
    output logic [LW-1:0] l_o,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          last_o
);

    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;
    logic [LW-1:0] l_q, l_d;

    always_comb begin
        i_o    = clear_i ? '0 : i_q;
        j_o    = clear_i ? '0 : j_q;
        k_o    = clear_i ? '0 : k_q;
        l_o    = clear_i ? '0 : l_q;
        row_o  = RW'(int'(i_o) * P + int'(k_o));
        col_o  = CW'(int'(j_o) * Q + int'(l_o));
        last_o = (i_o == IW'(M - 1)) && (j_o == JW'(N - 1)) &&
                 (k_o == KW'(P - 1)) && (l_o == LW'(Q - 1));

        i_d = i_o;
        j_d = j_o;
        k_d = k_o;
        l_d = l_o;
        if (advance_i) begin
            if (l_o == LW'(Q - 1)) begin
                l_d = '0;
                if (j_o == JW'(N - 1)) begin
                    j_d = '0;
                    if (k_o == KW'(P - 1)) begin
                        k_d = '0;
                        if (i_o == IW'(M - 1)) begin
                            i_d = '0;
                        end else begin
                            i_d = i_o + IW'(1);
                        end
                    end else begin
                        k_d = k_o + KW'(1);
                    end
                end else begin
                    j_d = j_o + JW'(1);
                end
            end else begin
                l_d = l_o + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
            l_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
            l_q <= l_d;
        end
    end

endmodule

// File: rtl/matrix_kronecker_stream.sv
// matrix_kronecker_stream: captures an A (m x n) and B (p x q) operand set and
// streams the (m*p) x (n*q) Kronecker product, one full-width element per
// cycle, row-major, with valid/ready back-pressure on the output.
// Optional build macro: MATRIX_KRON_SIGNED_EN -> two's complement operands with
// a sign-extended product; otherwise operands are unsigned.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (ready only while idle)
//   A, B                  flat operands, element [0][0] in the MSBs, row-major
//   out_valid / out_ready result handshake
//   out_data              A(i,j)*B(k,l), 2*word_size bits
//   out_row, out_col      result coordinates (i*p+k, j*q+l)
//   out_last              marks the final element of the result
module matrix_kronecker_stream
    import matrix_pkg::*;
#(
    parameter int word_size     = DEF_WORD_SIZE,
    parameter int Amatrixrownum = DEF_M,
    parameter int Amatrixcolnum = DEF_N,
    parameter int Bmatrixrownum = DEF_P,
    parameter int Bmatrixcolnum = DEF_Q
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic                                                        in_valid,
    output logic                                                        in_ready,
    input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0]            A,
    input  logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0]            B,
    output logic                                                        out_valid,
    input  logic                                                        out_ready,
    output logic [2*word_size-1:0]                                      out_data,
    output logic [idx_width(res_rows(Amatrixrownum, Bmatrixrownum))-1:0] out_row,
    output logic [idx_width(res_cols(Amatrixcolnum, Bmatrixcolnum))-1:0] out_col,
    output logic                                                        out_last
);

    localparam int W   = word_size;
    localparam int M   = Amatrixrownum;
    localparam int N   = Amatrixcolnum;
    localparam int P   = Bmatrixrownum;
    localparam int Q   = Bmatrixcolnum;
    localparam int NA  = M * N;
    localparam int NB  = P * Q;
    localparam int AIW = idx_width(NA);
    localparam int BIW = idx_width(NB);
    localparam int IW  = idx_width(M);
    localparam int JW  = idx_width(N);
    localparam int KW  = idx_width(P);
    localparam int LW  = idx_width(Q);
    localparam int RW  = idx_width(res_rows(M, P));
    localparam int CW  = idx_width(res_cols(N, Q));

    // Operand unpacking: flat bus element e (row-major) sits at slot NA-1-e.
    logic [W-1:0] a_in [NA];
    logic [W-1:0] b_in [NB];
    logic [W-1:0] a_q  [NA];
    logic [W-1:0] b_q  [NB];

    genvar gi;
    generate
        for (gi = 0; gi < NA; gi++) begin : g_a_unpack
            assign a_in[gi] = A[(NA-1-gi)*W +: W];
        end
        for (gi = 0; gi < NB; gi++) begin : g_b_unpack
            assign b_in[gi] = B[(NB-1-gi)*W +: W];
        end
    endgenerate

    kron_state_t     state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [2*W-1:0]  out_data_q;
    logic [RW-1:0]   out_row_q;
    logic [CW-1:0]   out_col_q;

    logic            accept;
    logic            load_run;
    logic            done;
    logic            load;

    logic [IW-1:0]   cnt_i;
    logic [JW-1:0]   cnt_j;
    logic [KW-1:0]   cnt_k;
    logic [LW-1:0]   cnt_l;
    logic [RW-1:0]   cnt_row;
    logic [CW-1:0]   cnt_col;
    logic            cnt_last;

    logic [AIW-1:0]  a_idx;
    logic [BIW-1:0]  b_idx;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [2*W-1:0]  a_ext;
    logic [2*W-1:0]  b_ext;
    logic [2*W-1:0]  prod;

    assign accept   = in_valid && in_ready_q && (state_q == S_IDLE);
    // In RUN out_valid is always high; the next element is fetched whenever the
    // current one is taken and it was not the final one.
    assign load_run = (state_q == S_RUN) && out_valid_q && out_ready && !out_last_q;
    assign done     = (state_q == S_RUN) && out_valid_q && out_ready && out_last_q;
    assign load     = accept || load_run;

    kron_index_counter #(
        .M(M), .N(N), .P(P), .Q(Q),
        .IW(IW), .JW(JW), .KW(KW), .LW(LW), .RW(RW), .CW(CW)
    ) u_index_counter (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (accept),
        .advance_i (load),
        .i_o       (cnt_i),
        .j_o       (cnt_j),
        .k_o       (cnt_k),
        .l_o       (cnt_l),
        .row_o     (cnt_row),
        .col_o     (cnt_col),
        .last_o    (cnt_last)
    );

    assign a_idx = AIW'(int'(cnt_i) * N + int'(cnt_j));
    assign b_idx = BIW'(int'(cnt_k) * Q + int'(cnt_l));

    // The first element is produced straight from the input buses in the
    // accept cycle (the counter selects position 0 then), which gives the
    // one-cycle operand-to-first-result latency.
    assign a_sel = accept ? a_in[0] : a_q[a_idx];
    assign b_sel = accept ? b_in[0] : b_q[b_idx];

`ifdef MATRIX_KRON_SIGNED_EN
    assign a_ext = {{W{a_sel[W-1]}}, a_sel};
    assign b_ext = {{W{b_sel[W-1]}}, b_sel};
`else
    assign a_ext = {{W{1'b0}}, a_sel};
    assign b_ext = {{W{1'b0}}, b_sel};
`endif

    // The low 2W bits of the product of the extended operands are the exact
    // full-precision result in both signed and unsigned modes.
    assign prod = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int e = 0; e < NA; e++) begin
                a_q[e] <= a_in[e];
            end
            for (int e = 0; e < NB; e++) begin
                b_q[e] <= b_in[e];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (done) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase

            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= prod;
                out_row_q   <= cnt_row;
                out_col_q   <= cnt_col;
                out_last_q  <= cnt_last;
            end else if (done) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_matrix_kronecker_stream.sv
`timescale 1ns/1ps
module tb_matrix_kronecker_stream;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- main DUT: 2x2 (x) 2x2 ----------------
    logic           in_valid, in_ready, out_valid, out_ready, out_last;
    logic [4*W-1:0] a_bus, b_bus;
    logic [2*W-1:0] out_data;
    logic [1:0]     out_row, out_col;

    matrix_kronecker_stream #(
        .word_size(W), .Amatrixrownum(2), .Amatrixcolnum(2),
        .Bmatrixrownum(2), .Bmatrixcolnum(2)
    ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_bus), .B(b_bus), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    // ---------------- non-square DUT: 1x3 (x) 2x1 ----------------
    logic           ns_in_valid, ns_in_ready, ns_out_valid, ns_out_ready, ns_out_last;
    logic [3*W-1:0] ns_a;
    logic [2*W-1:0] ns_b;
    logic [2*W-1:0] ns_out_data;
    logic [0:0]     ns_out_row;
    logic [1:0]     ns_out_col;

    matrix_kronecker_stream #(
        .word_size(W), .Amatrixrownum(1), .Amatrixcolnum(3),
        .Bmatrixrownum(2), .Bmatrixcolnum(1)
    ) u_dut_ns (
        .clk(clk), .rst(rst), .in_valid(ns_in_valid), .in_ready(ns_in_ready),
        .A(ns_a), .B(ns_b), .out_valid(ns_out_valid), .out_ready(ns_out_ready),
        .out_data(ns_out_data), .out_row(ns_out_row), .out_col(ns_out_col), .out_last(ns_out_last)
    );

    // ---------------- scalar DUT: 1x1 (x) 1x1 ----------------
    logic           s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
    logic [W-1:0]   s_a, s_b;
    logic [2*W-1:0] s_out_data;
    logic [0:0]     s_out_row, s_out_col;

    matrix_kronecker_stream #(
        .word_size(W), .Amatrixrownum(1), .Amatrixcolnum(1),
        .Bmatrixrownum(1), .Bmatrixcolnum(1)
    ) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .A(s_a), .B(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_row(s_out_row), .out_col(s_out_col), .out_last(s_out_last)
    );

    // ---------------- reference model and scoreboard (main DUT) ----------------
    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } elem_t;

    typedef struct {
        int          row;
        int          col;
        logic [63:0] data;
        logic        last;
    } vec_t;

    elem_t       exp_q[$];
    int          n_acc = 0;
    int          n_last = 0;
    int          last_acc_cyc = 0;
    int          acc_cyc = 0;
    logic [63:0] got_data [16];
    bit          stall_q = 1'b0;
    elem_t       held;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
`ifdef MATRIX_KRON_SIGNED_EN
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
`else
        return {32'h0, x} * {32'h0, y};
`endif
    endfunction

    // Kronecker product from its definition: result (r,c) = A(r/p, c/q) * B(r%p, c%q).
    task automatic push_expected(input logic [127:0] a, input logic [127:0] b);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int          ai, aj, bk, bl;
                logic [31:0] ae, be;
                elem_t       e;
                ai = r / 2; bk = r % 2;
                aj = c / 2; bl = c % 2;
                ae = a[(3 - (ai * 2 + aj)) * 32 +: 32];
                be = b[(3 - (bk * 2 + bl)) * 32 +: 32];
                e.data = ref_mul(ae, be);
                e.row  = 2'(r);
                e.col  = 2'(c);
                e.last = (r == 3) && (c == 3);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        elem_t act;
        elem_t e;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            act.data = out_data;
            act.row  = out_row;
            act.col  = out_col;
            act.last = out_last;
            if (stall_q) begin
                checks++;
                if (!out_valid || act != held) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%0b data=%h row=%0d col=%0d, want valid=1 data=%h row=%0d col=%0d",
                             out_valid, act.data, act.row, act.col, held.data, held.row, held.col);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                $display("elem row=%0d col=%0d data=%h last=%0b", out_row, out_col, out_data, out_last);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_element got row=%0d col=%0d data=%h, want none", out_row, out_col, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (act != e) begin
                        errors++;
                        $display("FAIL element got data=%h row=%0d col=%0d last=%0b, want data=%h row=%0d col=%0d last=%0b",
                                 act.data, act.row, act.col, act.last, e.data, e.row, e.col, e.last);
                    end
                end
                n_acc++;
                if (out_last) begin
                    n_last++;
                    last_acc_cyc = cycle_cnt;
                end
                got_data[{out_row, out_col}] = out_data;
            end
            stall_q = out_valid && !out_ready;
            held    = act;
        end
    end

    task automatic send_set(input logic [127:0] a, input logic [127:0] b, input bit keep);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        a_bus = a;
        b_bus = b;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout got in_ready=%0b, want 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        push_expected(a, b);
        acc_cyc = cycle_cnt;
        $display("accept set a=%h b=%h", a, b);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (!(out_valid && !in_ready && out_row == 2'd0 && out_col == 2'd0)) begin
            errors++;
            $display("FAIL first_latency got valid=%0b in_ready=%0b row=%0d col=%0d, want 1 0 0 0",
                     out_valid, in_ready, out_row, out_col);
        end
    endtask

    task automatic drain(input int mode);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d valid=%0b, want 0 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic run_set(input logic [127:0] a, input logic [127:0] b, input int mode);
        int a0, l0;
        a0 = n_acc;
        l0 = n_last;
        send_set(a, b, 1'b0);
        drain(mode);
        checks++;
        if (n_acc - a0 != 16) begin
            errors++;
            $display("FAIL element_count got %0d, want 16", n_acc - a0);
        end
        checks++;
        if (n_last - l0 != 1) begin
            errors++;
            $display("FAIL last_count got %0d, want 1", n_last - l0);
        end
    endtask

    task automatic check_main_table(input vec_t tab[8]);
        for (int t = 0; t < 8; t++) begin
            checks++;
            if (got_data[tab[t].row * 4 + tab[t].col] !== tab[t].data) begin
                errors++;
                $display("FAIL table_2x2 row=%0d col=%0d got %0d, want %0d", tab[t].row, tab[t].col,
                         got_data[tab[t].row * 4 + tab[t].col], tab[t].data);
            end
        end
    endtask

    vec_t        main_tab[8];
    vec_t        ns_tab[6];
    logic [127:0] dir_a, dir_b;
    logic [127:0] r_a, r_b;

    initial begin
        int a0, l0, idx, gap;
        logic [63:0] ns_got_data [6];
        int          ns_got_row [6];
        int          ns_got_col [6];
        logic        ns_got_last [6];
        logic [63:0] s_want;

        main_tab[0] = '{0, 0, 64'd0, 1'b0};
        main_tab[1] = '{0, 1, 64'd5, 1'b0};
        main_tab[2] = '{0, 2, 64'd0, 1'b0};
        main_tab[3] = '{0, 3, 64'd10, 1'b0};
        main_tab[4] = '{3, 0, 64'd18, 1'b0};
        main_tab[5] = '{3, 1, 64'd21, 1'b0};
        main_tab[6] = '{3, 2, 64'd24, 1'b0};
        main_tab[7] = '{3, 3, 64'd28, 1'b1};
        ns_tab[0] = '{0, 0, 64'd10, 1'b0};
        ns_tab[1] = '{0, 1, 64'd15, 1'b0};
        ns_tab[2] = '{0, 2, 64'd20, 1'b0};
        ns_tab[3] = '{1, 0, 64'd12, 1'b0};
        ns_tab[4] = '{1, 1, 64'd18, 1'b0};
        ns_tab[5] = '{1, 2, 64'd24, 1'b1};
`ifdef MATRIX_KRON_SIGNED_EN
        s_want = 64'd1;
`else
        s_want = 64'hFFFF_FFFE_0000_0001;
`endif
        dir_a = {32'd1, 32'd2, 32'd3, 32'd4};
        dir_b = {32'd0, 32'd5, 32'd6, 32'd7};

        rst = 1'b1;
        in_valid = 1'b0; a_bus = '0; b_bus = '0; out_ready = 1'b1;
        ns_in_valid = 1'b0; ns_a = '0; ns_b = '0; ns_out_ready = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // ---- reset state ----
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got in_ready=%0b out_valid=%0b out_last=%0b, want 0 0 0", in_ready, out_valid, out_last);
        end
        checks++;
        if (out_data !== 64'd0 || out_row !== 2'd0 || out_col !== 2'd0) begin
            errors++;
            $display("FAIL reset_data got data=%h row=%0d col=%0d, want 0 0 0", out_data, out_row, out_col);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || ns_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %0b%0b%0b, want 111", in_ready, ns_in_ready, s_in_ready);
        end

        // ---- non-square 1x3 (x) 2x1 ----
        ns_a = {32'd2, 32'd3, 32'd4};
        ns_b = {32'd5, 32'd6};
        ns_in_valid = 1'b1;
        @(posedge clk);
        #1;
        ns_in_valid = 1'b0;
        idx = 0;
        for (int n = 0; n < 40 && idx < 6; n++) begin
            @(negedge clk);
            if (ns_out_valid && ns_out_ready) begin
                ns_got_data[idx] = ns_out_data;
                ns_got_row[idx]  = int'(ns_out_row);
                ns_got_col[idx]  = int'(ns_out_col);
                ns_got_last[idx] = ns_out_last;
                $display("ns elem row=%0d col=%0d data=%0d last=%0b", ns_out_row, ns_out_col, ns_out_data, ns_out_last);
                idx++;
            end
        end
        checks++;
        if (idx != 6) begin
            errors++;
            $display("FAIL ns_count got %0d, want 6", idx);
        end
        for (int t = 0; t < idx; t++) begin
            checks++;
            if (ns_got_data[t] !== ns_tab[t].data || ns_got_row[t] != ns_tab[t].row ||
                ns_got_col[t] != ns_tab[t].col || ns_got_last[t] !== ns_tab[t].last) begin
                errors++;
                $display("FAIL ns_elem%0d got data=%0d row=%0d col=%0d last=%0b, want data=%0d row=%0d col=%0d last=%0b",
                         t, ns_got_data[t], ns_got_row[t], ns_got_col[t], ns_got_last[t],
                         ns_tab[t].data, ns_tab[t].row, ns_tab[t].col, ns_tab[t].last);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (ns_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ns_end_valid got %0b, want 0", ns_out_valid);
        end

        // ---- scalar 1x1 (x) 1x1, full-width product ----
        s_a = 32'hFFFF_FFFF;
        s_b = 32'hFFFF_FFFF;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        $display("scalar elem data=%h last=%0b", s_out_data, s_out_last);
        checks++;
        if (!(s_out_valid && s_out_last && s_out_row == 1'b0 && s_out_col == 1'b0) || s_out_data !== s_want) begin
            errors++;
            $display("FAIL scalar got valid=%0b last=%0b row=%0d col=%0d data=%h, want 1 1 0 0 %h",
                     s_out_valid, s_out_last, s_out_row, s_out_col, s_out_data, s_want);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL scalar_end got valid=%0b in_ready=%0b, want 0 1", s_out_valid, s_in_ready);
        end

        // ---- directed 2x2 (x) 2x2, out_ready held high ----
        for (int t = 0; t < 16; t++) got_data[t] = '1;
        run_set(dir_a, dir_b, 0);
        check_main_table(main_tab);

        // ---- same operands under 1010 back-pressure ----
        for (int t = 0; t < 16; t++) got_data[t] = '1;
        out_ready = 1'b1;
        run_set(dir_a, dir_b, 1);
        check_main_table(main_tab);

        // ---- random operands, random back-pressure ----
        for (int s = 0; s < 6; s++) begin
            r_a = {$urandom(), $urandom(), $urandom(), $urandom()};
            r_b = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_set(r_a, r_b, 2);
        end

        // ---- reset after the 5th accepted element ----
        a0 = n_acc;
        l0 = n_last;
        out_ready = 1'b1;
        send_set(dir_a, dir_b, 1'b0);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (n_acc >= a0 + 5) break;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0 ||
            out_data !== 64'd0 || out_row !== 2'd0 || out_col !== 2'd0) begin
            errors++;
            $display("FAIL abort_reset got valid=%0b last=%0b in_ready=%0b data=%h row=%0d col=%0d, want all 0",
                     out_valid, out_last, in_ready, out_data, out_row, out_col);
        end
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || n_last != l0 || n_acc != a0 + 5) begin
            errors++;
            $display("FAIL abort_recover got in_ready=%0b lasts=%0d accepted=%0d, want 1 0 5",
                     in_ready, n_last - l0, n_acc - a0);
        end
        r_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        r_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_set(r_a, r_b, 0);

        // ---- back-to-back: in_valid held across two sets ----
        a0 = n_acc;
        l0 = n_last;
        r_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        r_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_set(dir_a, dir_b, 1'b1);
        send_set(r_a, r_b, 1'b0);
        gap = acc_cyc - last_acc_cyc;
        drain(0);
        checks++;
        if (gap != 1) begin
            errors++;
            $display("FAIL b2b_gap got %0d cycles, want 1", gap);
        end
        checks++;
        if (n_acc - a0 != 32 || n_last - l0 != 2) begin
            errors++;
            $display("FAIL b2b_count got elements=%0d lasts=%0d, want 32 2", n_acc - a0, n_last - l0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
